dmem_bus_bridge: RTL and testbench
==================================

// Module: dmem_bus_bridge
// PURPOSE
// Sits between the pipelined core's data-memory port and a wait-stated valid/ready data bus.
// Latches each load/store request and runs one bus transaction per request.
// Stalls the core's MEM stage until the access completes, then returns read data.
// Converts misaligned accesses, bus errors and bus timeouts into a single-cycle access fault.
// PARAMETERS
// XLEN            32   data/address width
// TIMEOUT_CYCLES  255  max REQ-state cycles without bus_ready before fault (>=1)
// PORTS
// clk           in   1       clock, rising edge
// reset         in   1       asynchronous, active-low reset (asserted when 0)
// req_addr      in   XLEN    core dmem address
// req_wdata     in   XLEN    core store data, pre-lane-aligned
// req_byte_en   in   4       core byte lane enables
// req_wr_en     in   1       store request
// req_rd_en     in   1       load request
// pipe_hold     in   1       core is stalled for another reason; MEM result not consumed this cycle
// rsp_rdata     out  XLEN    load data, valid while state==DONE
// mem_stall     out  1       hold MEM stage and everything upstream
// access_fault  out  1       1-cycle pulse: request terminated without a valid transfer
// bus_valid     out  1       bus request valid
// bus_addr      out  XLEN    latched address, word-aligned ({addr[XLEN-1:2],2'b00})
// bus_wdata     out  XLEN    latched store data
// bus_byte_en   out  4       latched lane enables
// bus_we        out  1       1=write, 0=read
// bus_ready     in   1       bus accepts/completes the transfer
// bus_rdata     in   XLEN    read data, sampled when bus_valid&bus_ready
// bus_err       in   1       error response, sampled when bus_valid&bus_ready
// BEHAVIOUR
// Reset: state=IDLE; all outputs 0; latches and timeout counter cleared.
// Reset is immediate (asynchronous) even mid-transaction; bus_valid drops without waiting for bus_ready.
// FSM states: IDLE, REQ, DONE, FAULT.
// IDLE: request = req_rd_en|req_wr_en.
//   - Request present: mem_stall=1 combinationally.
//   - Misaligned request (byte_en==4'hF with addr[1:0]!=0; byte_en 4'b0011/4'b1100 with addr[0]!=0),
//     or rd_en&wr_en both set: go to FAULT, no bus cycle.
//   - Otherwise latch addr/wdata/byte_en/we, clear the timeout counter and go to REQ.
// REQ: bus_valid=1; payload stable until the handshake; mem_stall=1.
//   - Transfer occurs on bus_valid&bus_ready in the same cycle.
//   - bus_err=0: capture bus_rdata into rsp_rdata (reads only; unchanged on writes) and go to DONE.
//   - bus_err=1: go to FAULT.
//   - No ready: counter += 1; when counter==TIMEOUT_CYCLES-1 without ready, go to FAULT with bus_valid
//     dropped next cycle. A late bus_ready is ignored.
// DONE: mem_stall=0; rsp_rdata held.
//   - pipe_hold=1: stay in DONE and do not reissue.
//   - pipe_hold=0: go to IDLE.
// FAULT: access_fault=1 and mem_stall=0 for exactly one cycle; rsp_rdata=0.
//   - Then go to DONE-equivalent hold: wait in FAULT with access_fault=0 while pipe_hold=1.
//   - Go to IDLE when pipe_hold=0.
// Latency: request seen in IDLE at cycle N; bus_valid at N+1.
//   - Zero-wait bus (ready at N+1): DONE at N+2; mem_stall high for cycles N and N+1.
//   - Each bus wait state adds one stall cycle.
// At most one outstanding transaction. Request inputs are ignored outside IDLE; the core holds them
// stable while mem_stall=1.
// The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
// TESTING
// - Load, addr 0x100, bus_ready at first valid cycle, rdata 0xDEADBEEF -> stall 2 cycles,
//   DONE rsp_rdata=0xDEADBEEF, bus_we=0.
// - Store, addr 0x204, wdata 0x12345678, byte_en 4'hF, ready after 3 waits -> bus_addr=0x204,
//   bus_we=1, payload stable 4 cycles, stall 5 cycles.
// - Word load at addr 0x102 -> no bus_valid; access_fault pulses 1 cycle after request; mem_stall low in FAULT.
// - Bus never ready, TIMEOUT_CYCLES=4 -> bus_valid exactly 4 cycles; FAULT pulse;
//   later bus_ready ignored; next request proceeds normally.
// - DONE with pipe_hold=1 for 3 cycles, request held -> exactly one bus transaction; rsp_rdata constant.
// - Assert reset mid-REQ (bus_valid=1) -> all outputs 0 asynchronously;
//   after release the same request starts a fresh transaction.

Source files
------------

// File: rtl/dmem_bus_bridge.sv
// Bridge between the core's data-memory port and a wait-stated valid/ready bus.
// One transaction per request; misalignment, bus errors and timeouts become a one-cycle access fault.
module dmem_bus_bridge #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_byte_en,
    input  logic            req_wr_en,
    input  logic            req_rd_en,
    input  logic            pipe_hold,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            mem_stall,
    output logic            access_fault,
    output logic            bus_valid,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_byte_en,
    output logic            bus_we,
    input  logic            bus_ready,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_valid_q, bus_valid_d;
    logic              access_fault_q, access_fault_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_byte_en_q, bus_byte_en_d;
    logic              bus_we_q, bus_we_d;
    logic              stall_c;
    logic              misaligned_c;
    logic              req_c;

    assign req_c = req_rd_en | req_wr_en;

    // Alignment rules: full words need addr[1:0]==0, halfword lane pairs need addr[0]==0.
    always_comb begin
        misaligned_c = 1'b0;
        if (req_byte_en == 4'hF) begin
            misaligned_c = (req_addr[1:0] != 2'b00);
        end else if ((req_byte_en == 4'b0011) || (req_byte_en == 4'b1100)) begin
            misaligned_c = req_addr[0];
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus_valid_d    = 1'b0;
        access_fault_d = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        bus_addr_d     = bus_addr_q;
        bus_wdata_d    = bus_wdata_q;
        bus_byte_en_d  = bus_byte_en_q;
        bus_we_d       = bus_we_q;
        stall_c        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    stall_c = 1'b1;
                    if (misaligned_c || (req_rd_en && req_wr_en)) begin
                        state_d        = S_FAULT;
                        access_fault_d = 1'b1;
                        rsp_rdata_d    = '0;
                    end else begin
                        state_d       = S_REQ;
                        bus_valid_d   = 1'b1;
                        cnt_d         = '0;
                        bus_addr_d    = {req_addr[XLEN-1:2], 2'b00};
                        bus_wdata_d   = req_wdata;
                        bus_byte_en_d = req_byte_en;
                        bus_we_d      = req_wr_en;
                    end
                end
            end
            S_REQ: begin
                stall_c     = 1'b1;
                bus_valid_d = 1'b1;
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    if (bus_err) begin
                        state_d        = S_FAULT;
                        access_fault_d = 1'b1;
                        rsp_rdata_d    = '0;
                    end else begin
                        state_d = S_DONE;
                        if (!bus_we_q) begin
                            rsp_rdata_d = bus_rdata;
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Abandon the bus cycle; a later ready is never looked at.
                    bus_valid_d    = 1'b0;
                    state_d        = S_FAULT;
                    access_fault_d = 1'b1;
                    rsp_rdata_d    = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE, S_FAULT: begin
                if (!pipe_hold) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bus_valid_q    <= 1'b0;
            access_fault_q <= 1'b0;
            rsp_rdata_q    <= '0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            bus_byte_en_q  <= '0;
            bus_we_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus_valid_q    <= bus_valid_d;
            access_fault_q <= access_fault_d;
            rsp_rdata_q    <= rsp_rdata_d;
            bus_addr_q     <= bus_addr_d;
            bus_wdata_q    <= bus_wdata_d;
            bus_byte_en_q  <= bus_byte_en_d;
            bus_we_q       <= bus_we_d;
        end
    end

    // Stall is combinational so the core freezes in the cycle the request appears; forced low in reset.
    assign mem_stall    = reset & stall_c;
    assign rsp_rdata    = rsp_rdata_q;
    assign access_fault = access_fault_q;
    assign bus_valid    = bus_valid_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_byte_en  = bus_byte_en_q;
    assign bus_we       = bus_we_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: directed scenarios plus randomized accesses
// checked cycle by cycle against expectations derived from the access rules.
module tb_dmem_bus_bridge;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_byte_en;
    logic        req_wr_en, req_rd_en, pipe_hold;
    logic [31:0] rsp_rdata;
    logic        mem_stall, access_fault, bus_valid;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_byte_en;
    logic        bus_we, bus_ready, bus_err;
    logic [31:0] bus_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_rsp = 32'd0;

    always #5 clk = ~clk;

    dmem_bus_bridge #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
        .req_wr_en(req_wr_en), .req_rd_en(req_rd_en), .pipe_hold(pipe_hold),
        .rsp_rdata(rsp_rdata), .mem_stall(mem_stall), .access_fault(access_fault),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_byte_en(bus_byte_en), .bus_we(bus_we), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit misaligned(input logic [31:0] a, input logic [3:0] be);
        if (be == 4'hF) return a[1:0] != 2'b00;
        if (be == 4'b0011 || be == 4'b1100) return a[0];
        return 1'b0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus_valid), 32'd0);
        chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
        chk({tag, "_fault"}, 32'(access_fault), 32'd0);
        chk({tag, "_rsp"},   rsp_rdata, 32'd0);
        chk({tag, "_addr"},  bus_addr, 32'd0);
        chk({tag, "_wdata"}, bus_wdata, 32'd0);
        chk({tag, "_be"},    32'(bus_byte_en), 32'd0);
        chk({tag, "_we"},    32'(bus_we), 32'd0);
    endtask

    // One complete access from IDLE back to IDLE. Called at a negedge with the DUT idle.
    // waits = bus wait states before ready; waits >= TO means the bus never answers.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input logic wr, input logic rd, input int waits, input logic err,
                          input logic [31:0] rdat, input int hold);
        bit bad, fault;
        int stalls, exp_stalls;
        bad   = misaligned(a, be) || (wr && rd);
        fault = bad || (waits >= int'(TO)) || err;
        exp_stalls = bad ? 1 : ((waits < int'(TO)) ? waits + 2 : int'(TO) + 1);
        stalls = 0;

        req_addr = a; req_wdata = wd; req_byte_en = be; req_wr_en = wr; req_rd_en = rd;
        bus_ready = 1'b0; bus_err = 1'b0; pipe_hold = 1'b0;
        #1;
        chk("idle_stall", 32'(mem_stall), 32'd1);
        chk("idle_valid", 32'(bus_valid), 32'd0);
        if (mem_stall) stalls++;
        step();

        if (!bad) begin
            for (int w = 0; w < int'(TO); w++) begin
                bus_ready = (w == waits);
                bus_err   = err;
                bus_rdata = (w == waits) ? rdat : $urandom;
                pipe_hold = 1'($urandom_range(0, 1));
                #1;
                chk("req_valid", 32'(bus_valid), 32'd1);
                chk("req_stall", 32'(mem_stall), 32'd1);
                chk("req_fault", 32'(access_fault), 32'd0);
                chk("req_addr",  bus_addr, {a[31:2], 2'b00});
                chk("req_we",    32'(bus_we), 32'(wr));
                chk("req_wdata", bus_wdata, wd);
                chk("req_be",    32'(bus_byte_en), 32'(be));
                if (mem_stall) stalls++;
                step();
                if (w == waits) break;
            end
            bus_err = 1'b0;
        end

        if (fault) exp_rsp = 32'd0;
        else if (!wr) exp_rsp = rdat;

        // First cycle after the access; a stray late ready must be ignored.
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        pipe_hold = (hold > 0);
        #1;
        chk("end_fault", 32'(access_fault), 32'(fault));
        chk("end_stall", 32'(mem_stall), 32'd0);
        chk("end_valid", 32'(bus_valid), 32'd0);
        chk("end_rsp",   rsp_rdata, exp_rsp);
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));

        for (int h = 1; h <= hold; h++) begin
            step();
            pipe_hold = (h < hold);
            bus_ready = 1'($urandom_range(0, 1));
            #1;
            chk("hold_fault", 32'(access_fault), 32'd0);
            chk("hold_stall", 32'(mem_stall), 32'd0);
            chk("hold_valid", 32'(bus_valid), 32'd0);
            chk("hold_rsp",   rsp_rdata, exp_rsp);
        end

        req_rd_en = 1'b0; req_wr_en = 1'b0;
        step();
        bus_ready = 1'b0;
        #1;
        chk("back_idle_stall", 32'(mem_stall), 32'd0);
        chk("back_idle_valid", 32'(bus_valid), 32'd0);
        chk("back_idle_rsp",   rsp_rdata, exp_rsp);
        @(negedge clk);
    endtask

    logic [3:0] be_tab [7] = '{4'hF, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        reset = 1'b0;
        req_addr = '0; req_wdata = '0; req_byte_en = '0; req_wr_en = 1'b0; req_rd_en = 1'b0;
        pipe_hold = 1'b0; bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all_zero("post_reset");
        @(negedge clk);

        // Zero-wait load
        access(32'h100, 32'h0, 4'hF, 1'b0, 1'b1, 0, 1'b0, 32'hDEADBEEF, 0);
        // Store with three wait states; read data must be kept
        access(32'h204, 32'h12345678, 4'hF, 1'b1, 1'b0, 3, 1'b0, 32'h55AA55AA, 0);
        // Misaligned word load
        access(32'h102, 32'h0, 4'hF, 1'b0, 1'b1, 0, 1'b0, 32'h0, 0);
        // Bus never ready: timeout, then a normal request
        access(32'h80, 32'h0, 4'hF, 1'b0, 1'b1, int'(TO) + 2, 1'b0, 32'h0, 1);
        access(32'h84, 32'h0, 4'hF, 1'b0, 1'b1, 1, 1'b0, 32'hCAFEF00D, 0);
        // DONE held three cycles with the request still present
        access(32'h40, 32'h0, 4'hF, 1'b0, 1'b1, 0, 1'b0, 32'h0BADC0DE, 3);
        // Bus error on a store, then both enables at once
        access(32'h44, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 2, 1'b1, 32'h0, 0);
        access(32'h48, 32'h0, 4'hF, 1'b1, 1'b1, 0, 1'b0, 32'h0, 0);
        // Halfword boundary cases
        access(32'h4A, 32'h0, 4'b1100, 1'b0, 1'b1, 0, 1'b0, 32'h11112222, 0);
        access(32'h4B, 32'h0, 4'b0011, 1'b0, 1'b1, 0, 1'b0, 32'h0, 0);
        access(32'h103, 32'h0, 4'b1000, 1'b0, 1'b1, 0, 1'b0, 32'h33334444, 0);

        // Asynchronous reset in the middle of a bus cycle
        req_addr = 32'h300; req_wdata = '0; req_byte_en = 4'hF; req_wr_en = 1'b0; req_rd_en = 1'b1;
        bus_ready = 1'b0;
        step();
        step();
        #1;
        chk("pre_rst_valid", 32'(bus_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        exp_rsp = 32'd0;
        access(32'h300, 32'h0, 4'hF, 1'b0, 1'b1, 1, 1'b0, 32'h77778888, 0);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            int k;
            logic wr, rd;
            k  = int'($urandom_range(0, 9));
            wr = (k < 4);
            rd = (k >= 4) || (k == 0);
            access($urandom, $urandom, be_tab[$urandom_range(0, 6)], wr, rd,
                   int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0),
                   $urandom, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
